// File: rtl/irq_pkg.sv
// irq_pkg -- shared types and helpers for the interrupt controller.
//   irq_state_e    : controller FSM state (IDLE / REQ / INSVC)
//   IRQ_N_SRC_DEF  : default number of interrupt sources
//   irq_id_w()     : cause-ID width for a given source count
package irq_pkg;

    localparam int IRQ_N_SRC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        INSVC = 2'd2
    } irq_state_e;

    // A single source still needs a 1-bit ID.
    function automatic int irq_id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc -- combinational fixed-priority encoder, lowest index wins.
//   req   in  N   request vector
//   valid out 1   any request set
//   id    out W   index of lowest set request (0 when none)
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] id
);

    always_comb begin
        id = '0;
        // Scan downwards so the lowest set index is the last write.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) id = W'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl -- interrupt controller feeding the core's single interrupt input.
// Captures N_SRC sources (edge or level per EDGE_MASK), masks them, picks the
// lowest-index eligible one and runs the request -> ack -> in-service -> done
// handshake. One interrupt in service at a time, no nesting.
//
// Ports:
//   clk        in   1      core clock
//   rst        in   1      asynchronous reset, active low
//   src_irq    in   N_SRC  raw interrupt lines
//   en_mask    in   N_SRC  per-source enable
//   global_en  in   1      global interrupt enable
//   int_ack    in   1      core took the trap for int_id (pulse)
//   int_done   in   1      core executed mret (pulse)
//   int_req    out  1      interrupt request to the core
//   int_id     out  ID_W   cause ID being requested / in service
//   pending    out  N_SRC  pending bits
//   in_service out  1      high while an interrupt is being serviced
//
// Build option: define IRQ_SYNC_EN to put a 2-flop synchronizer on every
// src_irq bit (adds two cycles of latency). Without it src_irq must be
// synchronous to clk.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int               N_SRC     = IRQ_N_SRC_DEF,
    parameter logic [N_SRC-1:0] EDGE_MASK = {N_SRC{1'b1}},
    localparam int              ID_W      = irq_id_w(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_irq,
    input  logic [N_SRC-1:0] en_mask,
    input  logic             global_en,
    input  logic             int_ack,
    input  logic             int_done,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [N_SRC-1:0] pending,
    output logic             in_service
);

    irq_state_e       state;
    logic [N_SRC-1:0] src_s;
    logic [N_SRC-1:0] src_prev;
    logic [N_SRC-1:0] pend_nxt;
    logic [N_SRC-1:0] eligible;
    logic             win_vld;
    logic [ID_W-1:0]  win_id;
    logic             ack_take;

    // ---------------------------------------------------------------- input
`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= src_irq;
            sync_q2 <= sync_q1;
        end
    end

    assign src_s = sync_q2;
`else
    assign src_s = src_irq;
`endif

    // ------------------------------------------------------- pending capture
    // Only an ack actually taken in REQ clears an edge-pending bit.
    assign ack_take = (state == REQ) && int_ack;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        if (EDGE_MASK[i]) begin : g_edge
            // New rising edge wins over a same-cycle ack clear.
            assign pend_nxt[i] = (src_s[i] & ~src_prev[i]) |
                                 (pending[i] & ~(ack_take && (int_id == ID_W'(i))));
        end else begin : g_level
            assign pend_nxt[i] = src_s[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_prev <= '0;
            pending  <= '0;
        end else begin
            src_prev <= src_s;
            pending  <= pend_nxt;
        end
    end

    // ----------------------------------------------------------- arbitration
    assign eligible = pending & en_mask;

    irq_prio_enc #(
        .N (N_SRC),
        .W (ID_W)
    ) u_prio (
        .req   (eligible),
        .valid (win_vld),
        .id    (win_id)
    );

    // ------------------------------------------------------------------ FSM
    // int_id is latched on entry to REQ and held through INSVC, so a later
    // higher-priority arrival never changes the ID the core is looking at.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            int_id     <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (global_en && win_vld) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                        int_id  <= win_id;
                    end
                end
                REQ: begin
                    // An ack means the core already trapped, so it beats withdraw.
                    if (int_ack) begin
                        state      <= INSVC;
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                    end else if (!global_en || !eligible[int_id]) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                end
                INSVC: begin
                    if (int_done) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    int_req    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule
